// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Register-file checkpoint/restore controller: scans the GPRs into a shadow array and
// replays the shadow into the RF after a core setback pulse.
module cv32e40p_rf_recovery_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              backup_start_i,
  input  logic              recover_req_i,
  output logic              busy_o,
  output logic              backup_valid_o,
  output logic              recover_done_o,
  output logic              recover_err_o,
  output logic              setback_o,
  output logic              recover_o,
  output logic [ADDR_W-1:0] regfile_waddr_a_o,
  output logic [ADDR_W-1:0] regfile_waddr_b_o,
  output logic [31:0]       regfile_wdata_a_o,
  output logic [31:0]       regfile_wdata_b_o,
  output logic              regfile_we_a_o,
  output logic              regfile_we_b_o,
  output logic              regfile_backup_o,
  output logic [ADDR_W-1:0] regfile_raddr_ra_o,
  output logic [ADDR_W-1:0] regfile_raddr_rb_o,
  output logic [ADDR_W-1:0] regfile_raddr_rc_o,
  input  logic [31:0]       regfile_rdata_ra_i,
  input  logic [31:0]       regfile_rdata_rb_i,
  input  logic [31:0]       regfile_rdata_rc_i
);

  localparam int unsigned BackupBeats  = (NUM_REGS + 2) / 3;
  localparam int unsigned RestoreBeats = NUM_REGS / 2;
  localparam int unsigned IdxW         = $clog2(NUM_REGS);
  localparam int unsigned BeatW        = 6;

  localparam logic [BeatW-1:0] BackupLast  = BeatW'(BackupBeats - 1);
  localparam logic [BeatW-1:0] RestoreLast = BeatW'(RestoreBeats - 1);
  localparam logic [7:0]       NumRegs8    = 8'(NUM_REGS);

  typedef enum logic [2:0] {
    StIdle,
    StBackup,
    StSetback,
    StRestore,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             pending_q, pending_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [31:0]      shadow_q [NUM_REGS];

  // Backup scan slots: beat k reads 3k, 3k+1, 3k+2; slots past the RF end are masked.
  logic [7:0]       scan_base;
  logic [7:0]       scan_addr  [3];
  logic [31:0]      scan_rdata [3];
  logic [2:0]       scan_ok;

  logic [IdxW-1:0]  wr_idx_a, wr_idx_b;

  assign scan_rdata[0] = regfile_rdata_ra_i;
  assign scan_rdata[1] = regfile_rdata_rb_i;
  assign scan_rdata[2] = regfile_rdata_rc_i;

  always_comb begin
    scan_base = 8'(beat_q) * 8'd3;
    scan_ok   = '0;
    for (int j = 0; j < 3; j++) begin
      scan_addr[j] = scan_base + 8'(j);
      scan_ok[j]   = (state_q == StBackup) && (scan_addr[j] < NumRegs8);
    end
  end

  assign wr_idx_a = IdxW'({beat_q, 1'b0});
  assign wr_idx_b = IdxW'({beat_q, 1'b1});

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q + BeatW'(1);
    pending_d = pending_q;
    valid_d   = valid_q;
    err_d     = err_q;
    case (state_q)
      StIdle: begin
        beat_d = '0;
        if (recover_req_i) begin
          if (valid_q) begin
            state_d = StSetback;
          end else begin
            state_d = StDone;
            err_d   = 1'b1;
          end
        end else if (backup_start_i) begin
          state_d = StBackup;
          valid_d = 1'b0;
        end
      end
      StBackup: begin
        // A recovery request never aborts the scan; it is replayed from the fresh checkpoint.
        if (recover_req_i) begin
          pending_d = 1'b1;
        end
        if (beat_q == BackupLast) begin
          beat_d  = '0;
          valid_d = 1'b1;
          state_d = (pending_q || recover_req_i) ? StSetback : StIdle;
        end
      end
      StSetback: begin
        pending_d = 1'b0;
        beat_d    = '0;
        state_d   = StRestore;
      end
      StRestore: begin
        if (beat_q == RestoreLast) begin
          beat_d  = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        beat_d  = '0;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: begin
        beat_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Shadow contents are meaningless until a scan completes, so no reset.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < 3; j++) begin
      if (scan_ok[j]) begin
        shadow_q[scan_addr[j][IdxW-1:0]] <= scan_rdata[j];
      end
    end
  end

  always_comb begin
    busy_o             = (state_q != StIdle);
    backup_valid_o     = valid_q;
    recover_done_o     = (state_q == StDone);
    recover_err_o      = (state_q == StDone) && err_q;
    setback_o          = (state_q == StSetback);
    recover_o          = (state_q == StSetback) || (state_q == StRestore);
    regfile_we_a_o     = 1'b0;
    regfile_we_b_o     = 1'b0;
    regfile_waddr_a_o  = '0;
    regfile_waddr_b_o  = '0;
    regfile_wdata_a_o  = '0;
    regfile_wdata_b_o  = '0;
    regfile_backup_o   = (state_q == StBackup);
    regfile_raddr_ra_o = scan_ok[0] ? scan_addr[0][ADDR_W-1:0] : '0;
    regfile_raddr_rb_o = scan_ok[1] ? scan_addr[1][ADDR_W-1:0] : '0;
    regfile_raddr_rc_o = scan_ok[2] ? scan_addr[2][ADDR_W-1:0] : '0;
    if (state_q == StRestore) begin
      regfile_we_a_o    = 1'b1;
      regfile_we_b_o    = 1'b1;
      regfile_waddr_a_o = ADDR_W'({beat_q, 1'b0});
      regfile_waddr_b_o = ADDR_W'({beat_q, 1'b1});
      regfile_wdata_a_o = shadow_q[wr_idx_a];
      regfile_wdata_b_o = shadow_q[wr_idx_b];
    end
  end

endmodule

// File: tb/tb_cv32e40p_rf_recovery_ctrl.sv
// Bench for cv32e40p_rf_recovery_ctrl: a small RF model, a transaction-schedule reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_cv32e40p_rf_recovery_ctrl;

  localparam int N        = 32;
  localparam int BkBeats  = 11;
  localparam int RsBeats  = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        backup_start_i = 1'b0;
  logic        recover_req_i = 1'b0;
  logic        busy_o, backup_valid_o, recover_done_o, recover_err_o, setback_o, recover_o;
  logic [5:0]  waddr_a, waddr_b, raddr_ra, raddr_rb, raddr_rc;
  logic [31:0] wdata_a, wdata_b, rdata_ra, rdata_rb, rdata_rc;
  logic        we_a, we_b, backup_o;

  int n_checks = 0;
  int n_errors = 0;

  cv32e40p_rf_recovery_ctrl #(.NUM_REGS(N), .ADDR_W(6)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .backup_start_i     (backup_start_i),
    .recover_req_i      (recover_req_i),
    .busy_o             (busy_o),
    .backup_valid_o     (backup_valid_o),
    .recover_done_o     (recover_done_o),
    .recover_err_o      (recover_err_o),
    .setback_o          (setback_o),
    .recover_o          (recover_o),
    .regfile_waddr_a_o  (waddr_a),
    .regfile_waddr_b_o  (waddr_b),
    .regfile_wdata_a_o  (wdata_a),
    .regfile_wdata_b_o  (wdata_b),
    .regfile_we_a_o     (we_a),
    .regfile_we_b_o     (we_b),
    .regfile_backup_o   (backup_o),
    .regfile_raddr_ra_o (raddr_ra),
    .regfile_raddr_rb_o (raddr_rb),
    .regfile_raddr_rc_o (raddr_rc),
    .regfile_rdata_ra_i (rdata_ra),
    .regfile_rdata_rb_i (rdata_rb),
    .regfile_rdata_rc_i (rdata_rc)
  );

  always #5 clk_i = ~clk_i;

  // Register file with x0 hardwired to zero.
  logic [31:0] rf [N];
  assign rdata_ra = (raddr_ra == 6'd0) ? 32'd0 : rf[raddr_ra[4:0]];
  assign rdata_rb = (raddr_rb == 6'd0) ? 32'd0 : rf[raddr_rb[4:0]];
  assign rdata_rc = (raddr_rc == 6'd0) ? 32'd0 : rf[raddr_rc[4:0]];

  always @(posedge clk_i) begin
    if (we_a && waddr_a != 6'd0) rf[waddr_a[4:0]] <= wdata_a;
    if (we_b && waddr_b != 6'd0) rf[waddr_b[4:0]] <= wdata_b;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted command expands into its per-cycle output schedule.
  typedef struct packed {
    logic        busy, setback, recover, we, backup, done, err;
    logic [5:0]  wa, wb, ra, rb, rc;
    logic [31:0] da, db;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_shadow [N];
  bit          m_valid = 1'b0;
  bit          m_pend  = 1'b0;
  int          bk_beat = 0;

  function automatic logic [5:0] clamp(input int a);
    return (a < N) ? 6'(a) : 6'd0;
  endfunction

  function automatic void push_backup();
    exp_t e;
    for (int k = 0; k < BkBeats; k++) begin
      e = '0;
      e.busy = 1'b1; e.backup = 1'b1;
      e.ra = clamp(3 * k); e.rb = clamp(3 * k + 1); e.rc = clamp(3 * k + 2);
      q.push_back(e);
    end
    bk_beat = 0;
  endfunction

  function automatic void push_restore();
    exp_t e;
    e = '0; e.busy = 1'b1; e.setback = 1'b1; e.recover = 1'b1;
    q.push_back(e);
    for (int k = 0; k < RsBeats; k++) begin
      e = '0; e.busy = 1'b1; e.recover = 1'b1; e.we = 1'b1;
      e.wa = 6'(2 * k); e.wb = 6'(2 * k + 1);
      e.da = m_shadow[2 * k]; e.db = m_shadow[2 * k + 1];
      q.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    q.push_back(e);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        q.delete(); m_valid = 1'b0; m_pend = 1'b0; bk_beat = 0;
      end else if (q.size() == 0) begin
        if (recover_req_i) begin
          if (m_valid) push_restore();
          else begin
            e = '0; e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1;
            q.push_back(e);
          end
        end else if (backup_start_i) begin
          m_valid = 1'b0;
          push_backup();
        end
      end else begin
        e = q.pop_front();
        if (e.backup) begin
          if (recover_req_i) m_pend = 1'b1;
          for (int j = 0; j < 3; j++) begin
            if (3 * bk_beat + j < N) m_shadow[3 * bk_beat + j] = (3 * bk_beat + j == 0) ? 32'd0
                                                                   : rf[3 * bk_beat + j];
          end
          bk_beat++;
          if (bk_beat == BkBeats) begin
            m_valid = 1'b1;
            if (m_pend) begin
              push_restore();
              m_pend = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    exp_t cur;
    forever begin
      @(negedge clk_i);
      cur = (q.size() != 0) ? q[0] : '0;
      check("ctrl", 64'({busy_o, backup_valid_o, setback_o, recover_o, we_a, we_b, backup_o,
                         recover_done_o, recover_err_o}),
            64'({cur.busy, m_valid, cur.setback, cur.recover, cur.we, cur.we, cur.backup,
                 cur.done, cur.err}));
      check("waddr", 64'({waddr_a, waddr_b}), 64'({cur.wa, cur.wb}));
      check("wdata", {wdata_a, wdata_b}, {cur.da, cur.db});
      check("raddr", 64'({raddr_ra, raddr_rb, raddr_rc}), 64'({cur.ra, cur.rb, cur.rc}));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input bit bs, input bit rr);
    backup_start_i = bs;
    recover_req_i  = rr;
    step();
    backup_start_i = 1'b0;
    recover_req_i  = 1'b0;
  endtask

  initial begin
    int busy_cnt, sb, beats, done_c, sb_at, done_n;
    for (int i = 0; i < N; i++) rf[i] = 32'd0;
    repeat (3) step();
    rst_i = 1'b0;
    step();
    check("rst_busy_valid", 64'({busy_o, backup_valid_o}), 64'd0);
    check("rst_outs", 64'({setback_o, recover_o, we_a, we_b, recover_done_o, recover_err_o,
                           backup_o}), 64'd0);

    // Refused recovery with no checkpoint
    pulse(1'b0, 1'b1);
    check("ref_done_err", 64'({recover_done_o, recover_err_o, setback_o, we_a}), 64'b1100);
    step();
    check("ref_idle", 64'({busy_o, recover_done_o, recover_err_o}), 64'd0);

    // Checkpoint
    for (int i = 0; i < N; i++) rf[i] <= 32'hA5A5_0000 + 32'(i);
    step();
    pulse(1'b1, 1'b0);
    busy_cnt = 0;
    for (int k = 0; k < BkBeats; k++) begin
      if (busy_o) busy_cnt++;
      if (k == BkBeats - 1) begin
        check("clamp_raddr", 64'({raddr_ra, raddr_rb, raddr_rc}), 64'({6'd30, 6'd31, 6'd0}));
        check("clamp_valid_low", 64'(backup_valid_o), 64'd0);
      end
      step();
    end
    check("bk_busy_cycles", 64'(busy_cnt), 64'd11);
    check("bk_valid", 64'({busy_o, backup_valid_o}), 64'b01);

    // Corrupt the RF, then restore
    for (int i = 0; i < N; i++) rf[i] <= 32'd0;
    step();
    pulse(1'b0, 1'b1);
    sb = 0; beats = 0; done_c = -1;
    for (int c = 1; c <= 22; c++) begin
      if (setback_o) sb++;
      if (we_a) begin
        if (beats == 5) begin
          check("beat5_addr", 64'({waddr_a, waddr_b}), 64'({6'd10, 6'd11}));
          check("beat5_data", {wdata_a, wdata_b}, {32'hA5A5_000A, 32'hA5A5_000B});
        end
        beats++;
      end
      if (recover_done_o && done_c < 0) done_c = c;
      step();
    end
    check("setback_cycles", 64'(sb), 64'd1);
    check("restore_beats", 64'(beats), 64'd16);
    check("done_latency", 64'(done_c), 64'd18);
    for (int i = 1; i < N; i++) check("rf_restore", 64'(rf[i]), 64'(32'hA5A5_0000 + 32'(i)));

    // Recovery requested mid-scan uses the fresh checkpoint
    for (int i = 0; i < N; i++) rf[i] <= 32'h5A5A_0000 + 32'(i * 7);
    step();
    pulse(1'b1, 1'b0);
    sb_at = -1;
    for (int idx = 0; idx < 16; idx++) begin
      recover_req_i = (idx == 4);
      if (setback_o && sb_at < 0) begin
        sb_at = idx;
        for (int i = 0; i < N; i++) rf[i] <= 32'd0;
      end
      step();
    end
    recover_req_i = 1'b0;
    check("pend_setback_at", 64'(sb_at), 64'd11);
    for (int w = 0; w < 40 && busy_o; w++) step();
    check("pend_idle", 64'({busy_o, backup_valid_o}), 64'b01);
    for (int i = 1; i < N; i++) check("rf_fresh", 64'(rf[i]), 64'(32'h5A5A_0000 + 32'(i * 7)));

    // Simultaneous requests: recovery wins; request in RESTORE is dropped
    pulse(1'b1, 1'b1);
    check("simul_setback", 64'({setback_o, backup_o, backup_valid_o}), 64'b101);
    done_n = 0;
    for (int c = 1; c <= 40; c++) begin
      recover_req_i = (c == 5);
      if (recover_done_o) done_n++;
      step();
    end
    recover_req_i = 1'b0;
    check("simul_done_count", 64'(done_n), 64'd1);
    check("simul_valid_kept", 64'({busy_o, backup_valid_o}), 64'b01);

    // Asynchronous reset at RESTORE beat 7
    pulse(1'b0, 1'b1);
    repeat (8) step();
    check("mid_pre", 64'({recover_o, we_a, waddr_a}), 64'({1'b1, 1'b1, 6'd14}));
    rst_i = 1'b1;
    #1;
    check("mid_rst", 64'({recover_o, we_a, we_b, busy_o, backup_valid_o}), 64'd0);
    step();
    step();
    rst_i = 1'b0;
    step();
    check("post_rst", 64'({busy_o, backup_valid_o, recover_o}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_rf_recovery_ctrl.md
Name: cv32e40p_rf_recovery_ctrl

Overview:
Register-file checkpoint/restore controller that sits directly upstream of the core wrapper's RF recovery ports. On command it snapshots the GPR file into an internal shadow array through the three backup read ports. On a recovery request it pulses setback to the core, then replays the shadow into the RF through write ports A and B. It is intended for a redundancy/fault-recovery unit that detects core corruption and needs to roll the core back.

Parameters:
NUM_REGS, 32, number of RF entries checkpointed (64 when FPU=1 and PULP_ZFINX=0); even, 6..64.
ADDR_W, 6, RF address width; fixed to match the wrapper recovery ports.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
backup_start_i  in  1  single-cycle request to start a checkpoint scan
recover_req_i  in  1  single-cycle request to restore the RF from the shadow
busy_o  out  1  controller not in IDLE
backup_valid_o  out  1  shadow holds a complete checkpoint
recover_done_o  out  1  single-cycle pulse when recovery finishes
recover_err_o  out  1  single-cycle pulse, together with recover_done_o, when recovery was refused
setback_o  out  1  core setback
recover_o  out  1  core recover
regfile_waddr_a_o / regfile_waddr_b_o  out  6  restore write addresses
regfile_wdata_a_o / regfile_wdata_b_o  out  32  restore write data
regfile_we_a_o / regfile_we_b_o  out  1  restore write enables
regfile_backup_o  out  1  backup read strobe
regfile_raddr_ra_o / rb_o / rc_o  out  6  backup read addresses
regfile_rdata_ra_i / rb_i / rc_i  in  32  backup read data; combinational, valid in the same cycle as the addresses

Behaviour:
- Reset state: state=IDLE. All outputs are 0. Shadow array contents are don't-care. backup_valid_o=0. Pending flag=0.
- FSM states: IDLE, BACKUP, SETBACK, RESTORE, DONE. Beat counter `beat` is zeroed on every state entry.
- IDLE:
  - recover_req_i has priority over backup_start_i when both are asserted.
  - recover_req_i with backup_valid_o=1 -> SETBACK.
  - recover_req_i with backup_valid_o=0 -> DONE with the error flag set.
  - backup_start_i alone -> BACKUP; clear backup_valid_o on entry.
- BACKUP: one beat per cycle, ceil(NUM_REGS/3) beats (11 for 32).
  - Beat k: regfile_backup_o=1; raddr_ra/rb/rc = 3k, 3k+1, 3k+2.
  - At the clock edge, store each rdata into shadow[addr].
  - Any address >= NUM_REGS is driven as 0 and its shadow store is suppressed.
  - After the last beat: backup_valid_o<=1.
  - If the pending flag is set -> SETBACK; otherwise -> IDLE.
- recover_req_i during BACKUP sets the pending flag. The scan is not aborted, and recovery then uses the fresh checkpoint. backup_start_i during BACKUP is ignored.
- SETBACK: exactly one cycle with setback_o=1 and recover_o=1, no writes. Clear the pending flag. Next state is RESTORE.
- RESTORE: NUM_REGS/2 beats (16 for 32).
  - Beat k: recover_o=1, we_a=we_b=1, waddr_a=2k, waddr_b=2k+1, wdata from shadow.
  - After the last beat -> DONE.
- DONE: one cycle.
  - recover_done_o=1 always; recover_err_o=1 only if entered via the refused path.
  - Next state is IDLE. backup_valid_o is retained.
- Requests arriving in SETBACK/RESTORE/DONE are dropped, with no pending flag. backup_start_i arriving in SETBACK/RESTORE/DONE is dropped.
- busy_o=1 in all states except IDLE.
- Latencies (NUM_REGS=32):
  - Backup: 11 cycles of busy_o.
  - Recovery: 1+16+1=18 cycles from the cycle after the request to the end of done.
  - Total recovery busy including DONE: 18 cycles.
- All outputs are registered-state decodes; no output depends combinationally on any *_i except the shadow write path.
- rst_i asserted mid-operation forces IDLE immediately and drops setback_o, recover_o and all write enables. backup_valid_o is cleared.
- x0 is scanned and written like any register; the RF ignores writes to x0.

Test Plan:
- Backup then restore: preload RF with reg[i]=0xA5A50000+i, pulse backup_start_i, then overwrite the RF with 0. Pulse recover_req_i and expect:
  - setback_o for exactly 1 cycle;
  - 16 write beats, beat 5 = (10,0xA5A5000A),(11,0xA5A5000B);
  - recover_done_o 18 cycles after the request;
  - the RF equals the preload.
- Refused recovery: after reset, pulse recover_req_i -> next cycle recover_done_o=1 and recover_err_o=1; no setback_o and no write enables ever assert.
- Last-beat clamp: at the final BACKUP beat (k=10), expect raddr_ra=30, raddr_rb=31, raddr_rc=0, with no store for the rc slot; backup_valid_o rises after the 11th busy cycle.
- Request during backup: pulse recover_req_i at beat 4 of BACKUP. The scan completes (11 beats), then SETBACK follows immediately, and the restored data equals the fresh checkpoint.
- Simultaneous requests and drops:
  - backup_start_i and recover_req_i asserted in the same IDLE cycle with backup_valid_o=1 -> recovery is taken and the backup is dropped.
  - recover_req_i asserted during RESTORE beat 3 is ignored; exactly one recover_done_o is seen.
- Reset mid-restore: assert rst_i at RESTORE beat 7 -> in the same cycle (asynchronously) recover_o=0, we_a=we_b=0, busy_o=0, backup_valid_o=0.
